// File: rtl/systolic_feeder.sv
// Streams K beats from operand BRAMs A and B into an N-lane systolic array.
// Lane i is diagonally skewed by i cycles and tagged with valid/first/last.
module systolic_feeder #(
    parameter int BEAT_W   = 128,
    parameter int ELEM_W   = 8,
    parameter int BRAM_AW  = 8,
    parameter int LENGTH_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LENGTH_W-1:0]           k_len,
    output logic                          busy,
    output logic                          done,
    output logic [BRAM_AW-1:0]            bram_a_addr,
    output logic                          bram_a_en,
    input  logic [BEAT_W-1:0]             bram_a_rdata,
    output logic [BRAM_AW-1:0]            bram_b_addr,
    output logic                          bram_b_en,
    input  logic [BEAT_W-1:0]             bram_b_rdata,
    input  logic                          array_ready,
    output logic [BEAT_W-1:0]             a_data,
    output logic [BEAT_W-1:0]             b_data,
    output logic [BEAT_W/ELEM_W-1:0]      lane_valid,
    output logic [BEAT_W/ELEM_W-1:0]      lane_first,
    output logic [BEAT_W/ELEM_W-1:0]      lane_last
);
    localparam int N     = BEAT_W / ELEM_W;
    localparam int CNT_W = $clog2(N + 1);

    if (LENGTH_W > BRAM_AW) begin : g_len_check
        $fatal(1, "systolic_feeder: LENGTH_W must not exceed BRAM_AW");
    end

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t              state, state_next;
    logic [LENGTH_W-1:0] k_reg;
    logic [BRAM_AW-1:0]  addr;
    logic [BRAM_AW-1:0]  last_addr;
    logic [CNT_W-1:0]    drain_cnt;
    logic                issue;
    logic                tag_v, tag_f, tag_l;

    assign last_addr   = BRAM_AW'(k_reg) - BRAM_AW'(1);
    assign bram_a_addr = addr;
    assign bram_b_addr = addr;
    assign bram_a_en   = issue;
    assign bram_b_en   = issue;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (k_len == '0) ? DONE : FEED;
            end
            FEED: begin
                busy = 1'b1;
                if (array_ready) begin
                    issue = 1'b1;
                    if (addr == last_addr) state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (array_ready && drain_cnt == '0) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Drain covers one BRAM latency cycle plus N skew stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg     <= '0;
            addr      <= '0;
            drain_cnt <= '0;
            tag_v     <= 1'b0;
            tag_f     <= 1'b0;
            tag_l     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                k_reg <= k_len;
                addr  <= '0;
            end
            if (issue) addr <= addr + BRAM_AW'(1);
            if (state == FEED && state_next == DRAIN)
                drain_cnt <= CNT_W'(N);
            else if (state == DRAIN && array_ready && drain_cnt != '0)
                drain_cnt <= drain_cnt - CNT_W'(1);
            if (array_ready) begin
                tag_v <= issue;
                tag_f <= issue && (addr == '0);
                tag_l <= issue && (addr == last_addr);
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [ELEM_W-1:0] a_sr [i+1];
        logic [ELEM_W-1:0] b_sr [i+1];
        logic [i:0]        v_sr, f_sr, l_sr;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    a_sr[j] <= '0;
                    b_sr[j] <= '0;
                end
                v_sr <= '0;
                f_sr <= '0;
                l_sr <= '0;
            end else if (array_ready) begin
                a_sr[0] <= tag_v ? bram_a_rdata[i*ELEM_W +: ELEM_W] : '0;
                b_sr[0] <= tag_v ? bram_b_rdata[i*ELEM_W +: ELEM_W] : '0;
                v_sr[0] <= tag_v;
                f_sr[0] <= tag_f;
                l_sr[0] <= tag_l;
                for (int j = 1; j <= i; j++) begin
                    a_sr[j] <= a_sr[j-1];
                    b_sr[j] <= b_sr[j-1];
                    v_sr[j] <= v_sr[j-1];
                    f_sr[j] <= f_sr[j-1];
                    l_sr[j] <= l_sr[j-1];
                end
            end
        end

        assign a_data[i*ELEM_W +: ELEM_W] = a_sr[i];
        assign b_data[i*ELEM_W +: ELEM_W] = b_sr[i];
        assign lane_valid[i]              = v_sr[i];
        assign lane_first[i]              = f_sr[i];
        assign lane_last[i]               = l_sr[i];
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: a ready-cycle timeline model predicts
// every output on every cycle for directed and randomized runs.
module tb_systolic_feeder;
    localparam int BEAT_W = 128;
    localparam int ELEM_W = 8;
    localparam int N      = BEAT_W / ELEM_W;

    logic              clk = 1'b0;
    logic              rst, start, array_ready;
    logic [7:0]        k_len;
    logic              busy, done;
    logic [7:0]        bram_a_addr, bram_b_addr;
    logic              bram_a_en, bram_b_en;
    logic [BEAT_W-1:0] bram_a_rdata = '0, bram_b_rdata = '0;
    logic [BEAT_W-1:0] a_data, b_data;
    logic [N-1:0]      lane_valid, lane_first, lane_last;

    logic [BEAT_W-1:0] mem_a [256];
    logic [BEAT_W-1:0] mem_b [256];

    int n_checks = 0;
    int n_errors = 0;

    systolic_feeder dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done),
        .bram_a_addr(bram_a_addr), .bram_a_en(bram_a_en), .bram_a_rdata(bram_a_rdata),
        .bram_b_addr(bram_b_addr), .bram_b_en(bram_b_en), .bram_b_rdata(bram_b_rdata),
        .array_ready(array_ready), .a_data(a_data), .b_data(b_data),
        .lane_valid(lane_valid), .lane_first(lane_first), .lane_last(lane_last)
    );

    always #5 clk = ~clk;

    // BRAMs: one-cycle read latency, output held while disabled
    always @(posedge clk) begin
        if (bram_a_en) bram_a_rdata <= mem_a[bram_a_addr];
        if (bram_b_en) bram_b_rdata <= mem_b[bram_b_addr];
    end

    task automatic check_eq(input string tag, input logic [BEAT_W-1:0] got,
                            input logic [BEAT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input bit pattern);
        for (int k = 0; k < 256; k++)
            for (int i = 0; i < N; i++) begin
                mem_a[k][i*ELEM_W +: ELEM_W] = pattern ? 8'(k + 1)    : 8'($urandom);
                mem_b[k][i*ELEM_W +: ELEM_W] = pattern ? 8'(k + 'h10) : 8'($urandom);
            end
    endtask

    // Every stage advances only on ready cycles, so the stalled run equals the
    // stall-free timeline indexed by v = 1 + ready cycles seen since cycle 1.
    task automatic run(input int k, input int stall_at, input int stall_len,
                       input bit rand_stall, input int extra_start, input int reset_at);
        int v, end_c, kk, n_done;
        bit done_seen, dead, rdy;
        logic [BEAT_W-1:0] ea, eb;
        logic [N-1:0] ev, ef, el;
        bit en_exp, busy_exp, done_exp;
        v = 0; end_c = 1200; n_done = 0; done_seen = 0; dead = 0;
        for (int c = 0; c <= end_c; c++) begin
            rdy = rand_stall ? ($urandom_range(0, 3) != 0)
                             : !(c >= stall_at && c < stall_at + stall_len);
            array_ready = rdy;
            start       = (c == 0) || (c == extra_start);
            k_len       = 8'(k);
            rst         = (c == reset_at);
            @(negedge clk);
            dead = (reset_at >= 0) && (c > reset_at);
            ea = '0; eb = '0; ev = '0; ef = '0; el = '0;
            for (int i = 0; i < N; i++) begin
                kk = v - 3 - i;
                if (k > 0 && !dead && kk >= 0 && kk < k) begin
                    ev[i] = 1'b1;
                    ef[i] = (kk == 0);
                    el[i] = (kk == k - 1);
                    ea[i*ELEM_W +: ELEM_W] = mem_a[kk][i*ELEM_W +: ELEM_W];
                    eb[i*ELEM_W +: ELEM_W] = mem_b[kk][i*ELEM_W +: ELEM_W];
                end
            end
            en_exp   = k > 0 && !dead && rdy && v >= 1 && v <= k;
            busy_exp = k > 0 && !dead && v >= 1 && v <= k + N + 1;
            done_exp = !dead && !done_seen && ((k == 0) ? (c == 1) : (v == k + N + 2));
            check_eq("a_data", a_data, ea);
            check_eq("b_data", b_data, eb);
            check_eq("lane_valid", lane_valid, ev);
            check_eq("lane_first", lane_first, ef);
            check_eq("lane_last", lane_last, el);
            check_eq("busy", busy, busy_exp);
            check_eq("done", done, done_exp);
            check_eq("bram_a_en", bram_a_en, en_exp);
            check_eq("bram_b_en", bram_b_en, en_exp);
            if (en_exp) begin
                check_eq("bram_a_addr", bram_a_addr, v - 1);
                check_eq("bram_b_addr", bram_b_addr, v - 1);
            end
            if (done) n_done++;
            if (done_exp) begin
                done_seen = 1'b1;
                end_c = c + 3;
            end
            if (reset_at >= 0 && c == reset_at) end_c = c + 4;
            if (c == 0) v = 1;
            else if (rdy) v++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
        array_ready = 1'b1;
        check_eq("done_count", n_done, (reset_at >= 0) ? 0 : 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; array_ready = 1'b1; k_len = '0;
        fill_mem(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_en", {bram_a_en, bram_b_en}, 0);
        check_eq("reset_addr", {bram_a_addr, bram_b_addr}, 0);
        check_eq("reset_data", {a_data, b_data}, 0);
        check_eq("reset_tags", {lane_valid, lane_first, lane_last}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(4, 0, 0, 0, -1, -1);
        run(0, 0, 0, 0, -1, -1);
        fill_mem(1'b0);
        run(3, 2, 5, 0, -1, -1);
        run(4, 0, 0, 0, 5, -1);
        run(8, 0, 0, 0, -1, 8);
        run(2, 0, 0, 0, -1, -1);
        run(1, 0, 0, 0, -1, -1);
        for (int r = 0; r < 10; r++) begin
            fill_mem(1'b0);
            run($urandom_range(1, 40), 0, 0, 1, -1, -1);
        end
        run(1, 0, 0, 1, -1, -1);
        fill_mem(1'b0);
        run(255, 0, 0, 0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
